// File: rtl/dpram_port_arb.sv
// dpram_port_arb: round-robin arbiter sharing one registered-read DPRAM port between two requesters; define DPRAM_ARB_LOCK_EN for grant locking
module dpram_port_arb #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic             i_req0_we,
    input  logic             i_req0_lock,
    input  logic [AW-1:0]    i_req0_addr,
    input  logic [WIDTH-1:0] i_req0_wdata,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic             i_req1_we,
    input  logic             i_req1_lock,
    input  logic [AW-1:0]    i_req1_addr,
    input  logic [WIDTH-1:0] i_req1_wdata,
    output logic             o_rsp0_valid,
    output logic [WIDTH-1:0] o_rsp0_rdata,
    output logic             o_rsp1_valid,
    output logic [WIDTH-1:0] o_rsp1_rdata,
    output logic             o_ram_en,
    output logic             o_ram_we,
    output logic [AW-1:0]    o_ram_addr,
    output logic [WIDTH-1:0] o_ram_din,
    input  logic [WIDTH-1:0] i_ram_dout
);
    logic r_last_grant;
    logic r_rd_pend;
    logic r_rd_owner;
    logic w_allow0;
    logic w_allow1;
    logic w_c0;
    logic w_c1;
    logic w_g0;
    logic w_g1;
    logic w_acc;
    logic w_sel_we;

`ifdef DPRAM_ARB_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   w_owner_nxt;
    logic   w_lock_sel;

    assign w_lock_sel = w_g1 ? i_req1_lock : i_req0_lock;
    assign w_allow0   = !(r_state == LOCKED && r_owner);
    assign w_allow1   = !(r_state == LOCKED && !r_owner);

    // lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UNLOCKED;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // lock entry on a locking accept, exit on the owner's non-locking accept
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        if (w_acc && r_state == UNLOCKED && w_lock_sel) begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_g1;
        end else if (w_acc && r_state == LOCKED && !w_lock_sel) begin
            w_state_nxt = UNLOCKED;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = i_req0_lock ^ i_req1_lock;
    assign w_allow0      = 1'b1;
    assign w_allow1      = 1'b1;
`endif

    // candidates are masked by reset and lock; a tie goes to the requester not granted last
    assign w_c0     = i_req0_valid & ~rst & w_allow0;
    assign w_c1     = i_req1_valid & ~rst & w_allow1;
    assign w_g1     = w_c1 & (~w_c0 | ~r_last_grant);
    assign w_g0     = w_c0 & ~w_g1;
    assign w_acc    = w_g0 | w_g1;
    assign w_sel_we = w_g1 ? i_req1_we : i_req0_we;

    assign o_req0_ready = w_g0;
    assign o_req1_ready = w_g1;
    assign o_ram_en     = w_acc;
    assign o_ram_we     = w_acc & w_sel_we;
    assign o_ram_addr   = w_g1 ? i_req1_addr : w_g0 ? i_req0_addr : '0;
    assign o_ram_din    = w_g1 ? i_req1_wdata : w_g0 ? i_req0_wdata : '0;

    // response is suppressed during reset so an in-flight read is dropped
    assign o_rsp0_valid = r_rd_pend & ~r_rd_owner & ~rst;
    assign o_rsp1_valid = r_rd_pend & r_rd_owner & ~rst;
    assign o_rsp0_rdata = o_rsp0_valid ? i_ram_dout : '0;
    assign o_rsp1_rdata = o_rsp1_valid ? i_ram_dout : '0;

    // round-robin history and read-response tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            r_last_grant <= w_acc ? w_g1 : r_last_grant;
            r_rd_pend    <= w_acc & ~w_sel_we;
            r_rd_owner   <= w_acc & ~w_sel_we & w_g1;
        end
    end
endmodule

// File: tb/tb_dpram_port_arb.sv
// tb_dpram_port_arb: directed checks of the arbiter against a behavioural registered-read RAM
module tb_dpram_port_arb;
    localparam int WIDTH = 32;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req0_ready, req0_we = 1'b0, req0_lock = 1'b0;
    logic [AW-1:0]    req0_addr = '0;
    logic [WIDTH-1:0] req0_wdata = '0;
    logic             req1_valid = 1'b0, req1_ready, req1_we = 1'b0, req1_lock = 1'b0;
    logic [AW-1:0]    req1_addr = '0;
    logic [WIDTH-1:0] req1_wdata = '0;
    logic             rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp0_rdata, rsp1_rdata;
    logic             ram_en, ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_dout;
    logic [WIDTH-1:0] mem [4];
    int               n_tests = 0;
    int               n_fail = 0;

`ifdef DPRAM_ARB_LOCK_EN
    localparam logic [4:0] EXP_G1 = 5'b11000;
`else
    localparam logic [4:0] EXP_G1 = 5'b01010;
`endif

    dpram_port_arb #(.WIDTH(WIDTH), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_we(req0_we),
        .i_req0_lock(req0_lock), .i_req0_addr(req0_addr), .i_req0_wdata(req0_wdata),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_we(req1_we),
        .i_req1_lock(req1_lock), .i_req1_addr(req1_addr), .i_req1_wdata(req1_wdata),
        .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata),
        .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_din(ram_din),
        .i_ram_dout(ram_dout)
    );

    initial forever #5 clk = ~clk;

    // registered-read, read-before-write RAM port
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_din;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic idle;
        req0_valid = 1'b0; req0_we = 1'b0; req0_lock = 1'b0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_lock = 1'b0;
    endtask

    task automatic preload;
        logic [WIDTH-1:0] vals [4];
        vals = '{32'h0000_00A0, 32'h0000_00B1, 32'h0000_1234, 32'h0000_0000};
        for (int a = 0; a < 4; a++) begin
            req0_valid = 1'b1; req0_we = 1'b1; req0_addr = AW'(a); req0_wdata = vals[a];
            tick();
        end
        idle();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        tick();
        #2;
        n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0 got %b exp 0", req0_ready); end
        n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1 got %b exp 0", req1_ready); end
        n_tests++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en got %b exp 0", ram_en); end
        n_tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b%b exp 00", rsp0_valid, rsp1_valid); end
        n_tests++; if (rsp0_rdata !== '0) begin n_fail++; $display("FAIL reset_rsp0_rdata got %h exp 0", rsp0_rdata); end
        idle();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 2'd2;
        #2;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0 got %b exp 1", req0_ready); end
        n_tests++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL single_ram_en_we got %b%b exp 10", ram_en, ram_we); end
        n_tests++; if (ram_addr !== 2'd2) begin n_fail++; $display("FAIL single_ram_addr got %0d exp 2", ram_addr); end
        tick();
        idle();
        #2;
        n_tests++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp0_valid got %b exp 1", rsp0_valid); end
        n_tests++; if (rsp0_rdata !== 32'h1234) begin n_fail++; $display("FAIL single_rsp0_rdata got %h exp 00001234", rsp0_rdata); end
        n_tests++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp1_valid got %b exp 0", rsp1_valid); end
        n_tests++; if (ram_en !== 1'b0 || ram_addr !== '0) begin n_fail++; $display("FAIL single_idle_ram got en=%b addr=%0d exp en=0 addr=0", ram_en, ram_addr); end
        tick();
    endtask

    task automatic test_tie_rr;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                req0_valid = 1'b1; req0_addr = 2'd0;
                req1_valid = 1'b1; req1_addr = 2'd1;
            end else begin
                idle();
            end
            #2;
            if (i < 4) begin
                n_tests++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL tie_grant cycle %0d got %b%b exp %b%b", i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1); end
            end
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    n_tests++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_rdata !== 32'hA0) begin n_fail++; $display("FAIL tie_rsp0 cycle %0d got v=%b%b d=%h exp v=10 d=000000a0", i, rsp0_valid, rsp1_valid, rsp0_rdata); end
                end else begin
                    n_tests++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_rdata !== 32'hB1) begin n_fail++; $display("FAIL tie_rsp1 cycle %0d got v=%b%b d=%h exp v=01 d=000000b1", i, rsp0_valid, rsp1_valid, rsp1_rdata); end
                end
            end
            tick();
        end
    endtask

    task automatic test_write_then_read;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 2'd3; req1_wdata = 32'hDEAD;
        #2;
        n_tests++; if (req1_ready !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_accept got ready=%b we=%b exp 1 1", req1_ready, ram_we); end
        n_tests++; if (ram_din !== 32'hDEAD || ram_addr !== 2'd3) begin n_fail++; $display("FAIL wr_ram_drive got din=%h addr=%0d exp 0000dead 3", ram_din, ram_addr); end
        tick();
        req1_we = 1'b0;
        #2;
        n_tests++; if (rsp1_valid !== 1'b0 || req1_ready !== 1'b1) begin n_fail++; $display("FAIL wr_no_rsp got rsp=%b ready=%b exp 0 1", rsp1_valid, req1_ready); end
        tick();
        idle();
        #2;
        n_tests++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hDEAD || rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL wr_readback got v=%b%b d=%h exp v=01 d=0000dead", rsp0_valid, rsp1_valid, rsp1_rdata); end
        tick();
    endtask

    task automatic test_reset_midflight;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 2'd2;
        #2;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_accept got %b exp 1", req0_ready); end
        tick();
        rst = 1'b1;
        req1_valid = 1'b1; req1_addr = 2'd1;
        #2;
        n_tests++; if (rsp0_valid !== 1'b0 || rsp0_rdata !== '0) begin n_fail++; $display("FAIL mid_rsp_suppressed got v=%b d=%h exp 0 0", rsp0_valid, rsp0_rdata); end
        n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || ram_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle got r=%b%b en=%b exp 00 0", req0_ready, req1_ready, ram_en); end
        tick();
        rst = 1'b0;
        #2;
        n_tests++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL mid_pend_cleared got %b exp 0", rsp0_valid); end
        n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_tie_after_rst got %b%b exp 10", req0_ready, req1_ready); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_lock;
        int k;
        do_reset();
        k = 0;
        for (int c = 0; c < 5; c++) begin
            req0_valid = (k < 3); req0_we = 1'b1; req0_addr = 2'd0;
            req0_wdata = 32'h100 + WIDTH'(k); req0_lock = (k < 2);
            req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 2'd1;
            #2;
            n_tests++; if (req0_ready !== !EXP_G1[c] || req1_ready !== EXP_G1[c]) begin n_fail++; $display("FAIL lock_grant cycle %0d got %b%b exp %b%b", c, req0_ready, req1_ready, !EXP_G1[c], EXP_G1[c]); end
            if (!EXP_G1[c]) k++;
            tick();
        end
        idle();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 2'd0;
        tick();
        idle();
        #2;
        n_tests++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h102) begin n_fail++; $display("FAIL lock_readback got v=%b d=%h exp 1 00000102", rsp0_valid, rsp0_rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        preload();
        test_single_read();
        test_tie_rr();
        test_write_then_read();
        test_reset_midflight();
        test_lock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
